flow_cond_fsm: RTL
==================

FLOW_COND_FSM -- requirements
Module: flow_cond_fsm

Interface
REQ-001 SHALL have parameter NUM_FIFO, default 5, number of monitored FIFOs (Main, VC0, VC1, D0, D1 order at default).
REQ-002 SHALL have parameter THR_W, default 4, width of each per-FIFO threshold.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_L  in  1  asynchronous reset, active low.
REQ-005 SHALL have port init  in  1  request (re)configuration.
REQ-006 SHALL have port thr_high_in  in  NUM_FIFO*THR_W  packed high thresholds, FIFO i at bits [i*THR_W +: THR_W].
REQ-007 SHALL have port thr_low_in  in  NUM_FIFO*THR_W  packed low thresholds, same packing.
REQ-008 SHALL have port fifo_empty  in  NUM_FIFO  per-FIFO empty flags.
REQ-009 SHALL have port fifo_error  in  NUM_FIFO  per-FIFO overflow/underflow error pulses.
REQ-010 SHALL have port thr_high_out  out  NUM_FIFO*THR_W  latched high thresholds to the interconnect.
REQ-011 SHALL have port thr_low_out  out  NUM_FIFO*THR_W  latched low thresholds.
REQ-012 SHALL have ports idle_out, active_out, error_out  out  1 each  state indicators.
REQ-013 SHALL have port error_full  out  NUM_FIFO  sticky per-FIFO error record.
REQ-014 SHALL have port cfg_err  out  1  high when any latched channel has low >= high.
REQ-015 SHALL have port err_count  out  8  error-entry counter (see Configuration).

Function
REQ-016 States SHALL be RESET, INIT, IDLE, ACTIVE, ERROR, held in one state register.
REQ-017 RESET -> INIT on the first clk edge with reset_L high.
REQ-018 In INIT, thresholds SHALL be latched from inputs every edge; fifo_error SHALL be ignored.
REQ-019 INIT -> IDLE when init=0 and all input channels satisfy low < high (unsigned); otherwise stay in INIT.
REQ-020 cfg_err SHALL be registered: updated in INIT from the inputs sampled that edge, held elsewhere.
REQ-021 In IDLE/ACTIVE, transition priority SHALL be: any fifo_error bit -> ERROR; else init -> INIT; else IDLE -> ACTIVE if any fifo_empty=0, ACTIVE -> IDLE if all fifo_empty=1.
REQ-022 ERROR SHALL be exited only by init=1 (-> INIT) or reset; fifo_empty is ignored in ERROR.
REQ-023 idle_out, active_out, error_out SHALL be a one-hot decode of the state register (all 0 in RESET/INIT), valid the cycle after the causing edge.
REQ-024 error_full[i] SHALL set on any edge in IDLE/ACTIVE/ERROR with fifo_error[i]=1, stay set, and clear on the edge entering INIT.
REQ-025 Thresholds outside INIT SHALL hold; changes on inputs SHALL not propagate.
REQ-026 Simultaneous init and fifo_error in IDLE/ACTIVE: ERROR wins; in ERROR: INIT wins and error_full clears.

Reset
REQ-027 reset_L low SHALL asynchronously force state RESET, all thresholds 0, idle/active/error_out 0, error_full 0, cfg_err 0, err_count 0.
REQ-028 Reset asserted mid-operation SHALL discard all latched configuration; restart via INIT.

Configuration
REQ-029 Macro FLOW_COND_ERR_COUNT_EN defined: err_count increments on each IDLE->ERROR or ACTIVE->ERROR transition, saturates at 255, cleared only by reset (not init).
REQ-030 Macro undefined: err_count SHALL be constant 0 and no counter register synthesised.

Verification (NUM_FIFO=5, THR_W=4)
REQ-031 Reset release, init=1 two cycles with high=all 4'hC, low=all 4'h3, then init=0 -> state IDLE next edge, idle_out=1, thr_high_out=20'hCCCCC, cfg_err=0.
REQ-032 In INIT, channel 2 low=4'h8 high=4'h8 -> cfg_err=1, stays INIT with init=0; correct to low=4'h2 -> IDLE next edge.
REQ-033 In IDLE, fifo_empty=5'b11110 -> active_out=1; back to 5'b11111 -> idle_out=1.
REQ-034 In ACTIVE, fifo_error=5'b01000 one cycle with init=1 -> ERROR, error_full=5'b01000, err_count=1 (macro on) / 0 (off); then init=1 -> INIT, error_full=0, err_count unchanged.
REQ-035 256 error entries with macro on -> err_count=255 held; reset_L pulsed low mid-cycle -> all outputs 0 immediately, before next clk edge.

Source files
------------

// File: rtl/flow_cond_fsm.sv
// -----------------------------------------------------------------------------
// flow_cond_fsm
//
// Flow-control conditioning FSM for a set of monitored FIFOs. Thresholds are
// latched while in INIT and then held for the interconnect. The FSM tracks
// whether the FIFOs are idle or active, and records FIFO errors.
//
// States: RESET -> INIT -> IDLE <-> ACTIVE, with IDLE/ACTIVE -> ERROR.
// ERROR is left only through INIT (init=1) or reset.
//
// Optional feature macro: FLOW_COND_ERR_COUNT_EN
//   defined   : err_count counts IDLE/ACTIVE -> ERROR entries, saturating at
//               255, and is cleared only by reset.
//   undefined : err_count is tied to 0.
//
// Ports
//   clk           : clock, all state updates on the rising edge
//   reset_L       : asynchronous reset, active low
//   init          : request (re)configuration
//   thr_high_in   : packed high thresholds, FIFO i at [i*THR_W +: THR_W]
//   thr_low_in    : packed low thresholds, same packing
//   fifo_empty    : per-FIFO empty flags
//   fifo_error    : per-FIFO overflow/underflow error pulses
//   thr_high_out  : latched high thresholds
//   thr_low_out   : latched low thresholds
//   idle_out      : state is IDLE
//   active_out    : state is ACTIVE
//   error_out     : state is ERROR
//   error_full    : sticky per-FIFO error record
//   cfg_err       : some latched channel has low >= high
//   err_count     : error-entry counter
// -----------------------------------------------------------------------------
module flow_cond_fsm #(
    parameter int NUM_FIFO = 5,
    parameter int THR_W    = 4
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      init,
    input  logic [NUM_FIFO*THR_W-1:0] thr_high_in,
    input  logic [NUM_FIFO*THR_W-1:0] thr_low_in,
    input  logic [NUM_FIFO-1:0]       fifo_empty,
    input  logic [NUM_FIFO-1:0]       fifo_error,
    output logic [NUM_FIFO*THR_W-1:0] thr_high_out,
    output logic [NUM_FIFO*THR_W-1:0] thr_low_out,
    output logic                      idle_out,
    output logic                      active_out,
    output logic                      error_out,
    output logic [NUM_FIFO-1:0]       error_full,
    output logic                      cfg_err,
    output logic [7:0]                err_count
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [NUM_FIFO*THR_W-1:0] thr_high_reg;
    logic [NUM_FIFO*THR_W-1:0] thr_low_reg;
    logic                      cfg_err_reg;
    logic [NUM_FIFO-1:0]       error_full_reg;

    // Per-channel configuration check on the live inputs (unsigned compare).
    logic [NUM_FIFO-1:0] chan_bad;

    generate
        for (genvar gi = 0; gi < NUM_FIFO; gi++) begin : g_chan
            assign chan_bad[gi] = (thr_low_in[gi*THR_W +: THR_W] >=
                                   thr_high_in[gi*THR_W +: THR_W]);
        end
    endgenerate

    logic cfg_bad;
    logic any_err;
    logic all_empty;
    logic enter_init;
    logic in_run;

    assign cfg_bad   = |chan_bad;
    assign any_err   = |fifo_error;
    assign all_empty = &fifo_empty;
    assign in_run    = (state_reg == ST_IDLE) || (state_reg == ST_ACTIVE) ||
                       (state_reg == ST_ERROR);
    assign enter_init = (state_next == ST_INIT) && (state_reg != ST_INIT);

    // State register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_reg <= ST_RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and one-hot state decode.
    always_comb begin
        state_next = state_reg;
        idle_out   = 1'b0;
        active_out = 1'b0;
        error_out  = 1'b0;
        case (state_reg)
            ST_RESET: begin
                state_next = ST_INIT;
            end
            ST_INIT: begin
                if (!init && !cfg_bad) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                idle_out = 1'b1;
                // Error beats init, init beats the activity check.
                if (any_err)          state_next = ST_ERROR;
                else if (init)        state_next = ST_INIT;
                else if (!all_empty)  state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                active_out = 1'b1;
                if (any_err)          state_next = ST_ERROR;
                else if (init)        state_next = ST_INIT;
                else if (all_empty)   state_next = ST_IDLE;
            end
            ST_ERROR: begin
                error_out = 1'b1;
                if (init) state_next = ST_INIT;
            end
            default: begin
                state_next = ST_RESET;
            end
        endcase
    end

    // Thresholds and cfg_err are sampled only while in INIT, held elsewhere.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            thr_high_reg <= '0;
            thr_low_reg  <= '0;
            cfg_err_reg  <= 1'b0;
        end else if (state_reg == ST_INIT) begin
            thr_high_reg <= thr_high_in;
            thr_low_reg  <= thr_low_in;
            cfg_err_reg  <= cfg_bad;
        end
    end

    // Sticky error record. Clearing on entry to INIT takes priority, so an
    // init in ERROR wipes the record even if an error pulse arrives with it.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            error_full_reg <= '0;
        end else if (enter_init) begin
            error_full_reg <= '0;
        end else if (in_run) begin
            error_full_reg <= error_full_reg | fifo_error;
        end
    end

`ifdef FLOW_COND_ERR_COUNT_EN
    logic       err_entry;
    logic [7:0] err_count_reg;

    assign err_entry = (state_next == ST_ERROR) &&
                       ((state_reg == ST_IDLE) || (state_reg == ST_ACTIVE));

    // Saturating counter; init does not clear it.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_count_reg <= 8'd0;
        end else if (err_entry && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign err_count = err_count_reg;
`else
    assign err_count = 8'd0;
`endif

    assign thr_high_out = thr_high_reg;
    assign thr_low_out  = thr_low_reg;
    assign cfg_err      = cfg_err_reg;
    assign error_full   = error_full_reg;

endmodule
